// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Single-port SRAM sequencer shared by the EPROM-socket target port
//            and the SPI-loader host port. Grants one request at a time in
//            IDLE, drives registered SRAM strobes with parameterised wait
//            states and returns read data with one-clock completion pulses.
// Options  : SRAM_ARB_FAIRNESS_EN - bounds the number of consecutive target
//            grants while the host is waiting (MAX_TGT_STREAK).
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_WIDTH     = 18,
    parameter int DATA_WIDTH     = 8,
    parameter int RD_CYCLES      = 2,
    parameter int WR_CYCLES      = 2,
    parameter int MAX_TGT_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tgt_req,
    input  logic [ADDR_WIDTH-1:0] tgt_addr,
    output logic                  tgt_ack,
    output logic [DATA_WIDTH-1:0] tgt_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  sram_doe,
    input  logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  busy
);

    localparam int C_MAX_RW  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int C_MAX_CNT = (C_MAX_RW > MAX_TGT_STREAK) ? C_MAX_RW : MAX_TGT_STREAK;
    localparam int C_CNT_W   = $clog2(C_MAX_CNT + 1);

    localparam logic [C_CNT_W-1:0] C_ONE     = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_RD_LAST = C_CNT_W'(RD_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_WR_LAST = C_CNT_W'(WR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_TURN     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_gnt_host;     // 1 = current access belongs to host
    logic                 w_gnt_host_nxt;
    logic                 w_grant_tgt;
    logic                 w_grant_host;
    logic                 w_capture;
    logic                 w_host_prio;    // fairness override in IDLE
    logic                 w_ce;
    logic                 w_oe;
    logic                 w_we;
    logic                 w_doe;

`ifdef SRAM_ARB_FAIRNESS_EN
    localparam logic [C_CNT_W-1:0] C_STREAK_MAX = C_CNT_W'(MAX_TGT_STREAK);

    logic [C_CNT_W-1:0] r_streak;

    assign w_host_prio = (r_streak == C_STREAK_MAX);

    // Count target grants made while the host is kept waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_host || !host_req) begin
                r_streak <= '0;
            end else if (w_grant_tgt) begin
                r_streak <= r_streak + C_ONE;
            end
        end
    end
`else
    assign w_host_prio = 1'b0;
`endif

    assign busy = (r_state != S_IDLE);

    // Next-state, grant and wait-state counter decode
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_gnt_host_nxt = r_gnt_host;
        w_grant_tgt    = 1'b0;
        w_grant_host   = 1'b0;
        w_capture      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (tgt_req && !(host_req && w_host_prio)) begin
                    w_grant_tgt    = 1'b1;
                    w_gnt_host_nxt = 1'b0;
                    w_state_nxt    = S_RD;
                end else if (host_req) begin
                    w_grant_host   = 1'b1;
                    w_gnt_host_nxt = 1'b1;
                    w_state_nxt    = host_we ? S_WR_SETUP : S_RD;
                end
            end
            S_RD: begin
                if (r_cnt == C_RD_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_TURN;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_WR_SETUP: begin
                w_state_nxt = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (r_cnt == C_WR_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WR_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_WR_HOLD: begin
                w_state_nxt = S_TURN;
            end
            S_TURN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so they leave flops cleanly
    always_comb begin
        w_ce  = (w_state_nxt == S_RD) || (w_state_nxt == S_WR_SETUP) ||
                (w_state_nxt == S_WR_PULSE) || (w_state_nxt == S_WR_HOLD);
        w_oe  = (w_state_nxt == S_RD);
        w_we  = (w_state_nxt == S_WR_PULSE);
        w_doe = (w_state_nxt == S_WR_SETUP) || (w_state_nxt == S_WR_PULSE) ||
                (w_state_nxt == S_WR_HOLD);
    end

    // State, registered SRAM pins, grant latching and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_gnt_host <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_doe   <= 1'b0;
            sram_addr  <= '0;
            sram_dout  <= '0;
            tgt_rdata  <= '0;
            host_rdata <= '0;
            tgt_ack    <= 1'b0;
            host_ack   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gnt_host <= w_gnt_host_nxt;
            sram_ce_n  <= ~w_ce;
            sram_oe_n  <= ~w_oe;
            sram_we_n  <= ~w_we;
            sram_doe   <= w_doe;
            tgt_ack    <= (w_state_nxt == S_TURN) && !w_gnt_host_nxt;
            host_ack   <= (w_state_nxt == S_TURN) && w_gnt_host_nxt;
            if (w_grant_tgt) begin
                sram_addr <= tgt_addr;
            end else if (w_grant_host) begin
                sram_addr <= host_addr;
                if (host_we) begin
                    sram_dout <= host_wdata;
                end
            end
            if (w_capture) begin
                if (r_gnt_host) begin
                    host_rdata <= sram_din;
                end else begin
                    tgt_rdata <= sram_din;
                end
            end
        end
    end

    // Never drive the data bus while the SRAM drives it; acks are exclusive
    a_no_bus_contention: assert property (@(posedge clk) disable iff (!rst_n)
        !(sram_doe && !sram_oe_n));
    a_ack_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(tgt_ack && host_ack));

endmodule
`default_nettype wire
